// File: rtl/fsm_sar_pkg.sv
// Shared types and helpers for the multi-channel SAR controller.
// Holds the scan-state encoding, the comparator polarity and the mux-select width rule.
package fsm_sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_HOLD    = 3'd4
  } sar_state_e;

  // Comparator level meaning "Vin >= Vdac, keep the trial bit"
  localparam logic CMP_KEEP = 1'b1;

  // Mux-select width: a single channel still needs one select bit
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// One successive-approximation binary search, MSB first.
// Each trial is held SettleCycles+1 cycles; the comparator is read on the last one.
module sar_bit_engine
  import fsm_sar_pkg::*;
#(
  parameter int Width        = 6,
  parameter int SettleCycles = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             go_i,
  input  logic             cmp_i,
  output logic [Width-1:0] code_o,
  output logic             done_o
);

  localparam int            BW          = $clog2(Width);
  localparam logic [BW-1:0] BIT_MSB     = BW'(Width - 1);
  localparam logic [BW-1:0] BIT_ONE     = BW'(1);
  localparam logic [3:0]    SETTLE_LAST = 4'(SettleCycles);

  logic [Width-1:0] code_r, code_s;
  logic [BW-1:0]    bit_r, bit_s;
  logic [3:0]       settle_r, settle_s;
  logic             active_r, active_s;
  logic             resolve_s;

  assign resolve_s = active_r && (settle_r == SETTLE_LAST);
  assign done_o    = resolve_s && (bit_r == '0);
  assign code_o    = code_r;

  // Next trial code: resolve the current bit, then raise the next lower one
  always_comb begin
    code_s   = code_r;
    bit_s    = bit_r;
    settle_s = settle_r;
    active_s = active_r;
    if (clr_i) begin
      code_s   = '0;
      bit_s    = '0;
      settle_s = '0;
      active_s = 1'b0;
    end else if (go_i) begin
      code_s          = '0;
      code_s[BIT_MSB] = 1'b1;
      bit_s           = BIT_MSB;
      settle_s        = '0;
      active_s        = 1'b1;
    end else if (resolve_s) begin
      code_s[bit_r] = (cmp_i == CMP_KEEP);
      settle_s      = '0;
      if (bit_r == '0) begin
        active_s = 1'b0;
      end else begin
        bit_s         = bit_r - BIT_ONE;
        code_s[bit_s] = 1'b1;
      end
    end else if (active_r) begin
      settle_s = settle_r + 4'd1;
    end else begin
      active_s = 1'b0;
    end
  end

  // Search state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_r   <= '0;
      bit_r    <= '0;
      settle_r <= '0;
      active_r <= 1'b0;
    end else begin
      code_r   <= code_s;
      bit_r    <= bit_s;
      settle_r <= settle_s;
      active_r <= active_s;
    end
  end

endmodule

// File: rtl/fsm_sar_mc.sv
// Multi-channel SAR ADC controller: channel scan, sample/convert sequencing,
// power-of-two averaging and a single-entry valid/ready result slot.
module fsm_sar_mc
  import fsm_sar_pkg::*;
#(
  parameter int Width        = 6,
  parameter int Channels     = 4,
  parameter int SampleCycles = 2,
  parameter int SettleCycles = 0,
  parameter int AvgLog2      = 0,
  parameter int ChW          = ch_width(Channels)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                cont_i,
  input  logic                abort_i,
  input  logic [Channels-1:0] ch_mask_i,
  input  logic                cmp_i,
  output logic                sample_o,
  output logic [Width-1:0]    dac_o,
  output logic [ChW-1:0]      ch_sel_o,
  output logic                busy_o,
  output logic [Width-1:0]    result_o,
  output logic [ChW-1:0]      result_ch_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                eoc_o
);

  localparam int             AW        = Width + AvgLog2;
  localparam int             AVW       = AvgLog2 + 1;
  localparam int             SW        = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;
  localparam logic [SW-1:0]  SAMP_LAST = SW'(SampleCycles - 1);
  localparam logic [SW-1:0]  SAMP_ONE  = SW'(1);
  localparam logic [AVW-1:0] AVG_LAST  = AVW'((1 << AvgLog2) - 1);
  localparam logic [AVW-1:0] AVG_ONE   = AVW'(1);

  sar_state_e          state_r, state_s;
  logic [Channels-1:0] mask_r, mask_s;
  logic [ChW-1:0]      ch_r, ch_s;
  logic [SW-1:0]       samp_cnt_r, samp_cnt_s;
  logic [AVW-1:0]      avg_cnt_r, avg_cnt_s;
  logic [AW-1:0]       acc_r, acc_s, acc_sum_s, wr_acc_s;
  logic [Width-1:0]    result_r, result_s;
  logic [ChW-1:0]      result_ch_r, result_ch_s;
  logic                valid_r, valid_s;
  logic                eoc_r, eoc_s;
  logic                busy_r, sample_r;
  logic                slot_free_s, slot_wr_s, advance_s;
  logic [ChW-1:0]      low_new_s, nxt_ch_s;
  logic                nxt_found_s;
  logic                eng_clr_s, eng_go_s, eng_done_s;
  logic [Width-1:0]    eng_code_s;

  sar_bit_engine #(
    .Width        (Width),
    .SettleCycles (SettleCycles)
  ) u_engine (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (eng_clr_s),
    .go_i   (eng_go_s),
    .cmp_i  (cmp_i),
    .code_o (eng_code_s),
    .done_o (eng_done_s)
  );

  // Lowest enabled channel of the incoming mask and next enabled channel above the current one
  always_comb begin
    low_new_s   = '0;
    nxt_ch_s    = '0;
    nxt_found_s = 1'b0;
    for (int i = Channels - 1; i >= 0; i--) begin
      if (ch_mask_i[i]) begin
        low_new_s = ChW'(i);
      end else begin
        low_new_s = low_new_s;
      end
      if (mask_r[i] && (ChW'(i) > ch_r)) begin
        nxt_ch_s    = ChW'(i);
        nxt_found_s = 1'b1;
      end else begin
        nxt_found_s = nxt_found_s;
      end
    end
  end

  // Scan FSM next state, accumulator and result-slot updates
  always_comb begin
    state_s     = state_r;
    mask_s      = mask_r;
    ch_s        = ch_r;
    samp_cnt_s  = samp_cnt_r;
    avg_cnt_s   = avg_cnt_r;
    acc_s       = acc_r;
    result_s    = result_r;
    result_ch_s = result_ch_r;
    eoc_s       = 1'b0;
    eng_clr_s   = 1'b0;
    eng_go_s    = 1'b0;
    slot_wr_s   = 1'b0;
    advance_s   = 1'b0;
    acc_sum_s   = acc_r + AW'(eng_code_s);
    wr_acc_s    = acc_r;
    slot_free_s = !valid_r || result_ready_i;

    case (state_r)
      ST_IDLE: begin
        if (start_i && (ch_mask_i != '0)) begin
          mask_s     = ch_mask_i;
          ch_s       = low_new_s;
          samp_cnt_s = '0;
          avg_cnt_s  = '0;
          acc_s      = '0;
          eng_clr_s  = 1'b1;
          state_s    = ST_SAMPLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SAMPLE: begin
        if (samp_cnt_r == SAMP_LAST) begin
          eng_go_s = 1'b1;
          state_s  = ST_CONVERT;
        end else begin
          samp_cnt_s = samp_cnt_r + SAMP_ONE;
        end
      end
      ST_CONVERT: begin
        if (eng_done_s) begin
          state_s = ST_ACCUM;
        end else begin
          state_s = ST_CONVERT;
        end
      end
      ST_ACCUM: begin
        acc_s = acc_sum_s;
        if (avg_cnt_r != AVG_LAST) begin
          avg_cnt_s  = avg_cnt_r + AVG_ONE;
          samp_cnt_s = '0;
          eng_clr_s  = 1'b1;
          state_s    = ST_SAMPLE;
        end else if (slot_free_s) begin
          wr_acc_s  = acc_sum_s;
          advance_s = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (slot_free_s) begin
          advance_s = 1'b1;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Write the averaged code and move to the next enabled channel or end the pass
    if (advance_s) begin
      slot_wr_s   = 1'b1;
      result_s    = Width'(wr_acc_s >> AvgLog2);
      result_ch_s = ch_r;
      acc_s       = '0;
      avg_cnt_s   = '0;
      samp_cnt_s  = '0;
      eng_clr_s   = 1'b1;
      if (nxt_found_s) begin
        ch_s    = nxt_ch_s;
        state_s = ST_SAMPLE;
      end else begin
        eoc_s = 1'b1;
        if (cont_i && (ch_mask_i != '0)) begin
          mask_s  = ch_mask_i;
          ch_s    = low_new_s;
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
    end else begin
      slot_wr_s = 1'b0;
    end

    // Abort wins over everything but leaves the result slot alone
    if (abort_i && (state_r != ST_IDLE)) begin
      state_s     = ST_IDLE;
      mask_s      = mask_r;
      ch_s        = ch_r;
      samp_cnt_s  = '0;
      avg_cnt_s   = '0;
      acc_s       = '0;
      result_s    = result_r;
      result_ch_s = result_ch_r;
      eoc_s       = 1'b0;
      slot_wr_s   = 1'b0;
      eng_go_s    = 1'b0;
      eng_clr_s   = 1'b1;
    end else begin
      eng_clr_s = eng_clr_s;
    end

    if (slot_wr_s) begin
      valid_s = 1'b1;
    end else if (valid_r && result_ready_i) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // Scan FSM, accumulator, result slot and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      mask_r      <= '0;
      ch_r        <= '0;
      samp_cnt_r  <= '0;
      avg_cnt_r   <= '0;
      acc_r       <= '0;
      result_r    <= '0;
      result_ch_r <= '0;
      valid_r     <= 1'b0;
      eoc_r       <= 1'b0;
      busy_r      <= 1'b0;
      sample_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      mask_r      <= mask_s;
      ch_r        <= ch_s;
      samp_cnt_r  <= samp_cnt_s;
      avg_cnt_r   <= avg_cnt_s;
      acc_r       <= acc_s;
      result_r    <= result_s;
      result_ch_r <= result_ch_s;
      valid_r     <= valid_s;
      eoc_r       <= eoc_s;
      busy_r      <= (state_s != ST_IDLE);
      sample_r    <= (state_s == ST_SAMPLE);
    end
  end

  assign sample_o       = sample_r;
  assign dac_o          = eng_code_s;
  assign ch_sel_o       = ch_r;
  assign busy_o         = busy_r;
  assign result_o       = result_r;
  assign result_ch_o    = result_ch_r;
  assign result_valid_o = valid_r;
  assign eoc_o          = eoc_r;

endmodule

// File: tb/tb_fsm_sar_mc.sv
// Scoreboard bench for fsm_sar_mc: default instance plus a settle-3 and an average-of-4 instance.
// Stimulus pushes expected {channel, code} pairs; a negedge monitor pops them on each valid&ready.
module tb_fsm_sar_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_m = 1'b0, start_s = 1'b0, start_a = 1'b0;
  logic       cont = 1'b0, abort = 1'b0, ready = 1'b1;
  logic [3:0] mask = 4'd0;

  logic       cmp_m, cmp_s, cmp_a;
  logic       sample_m, sample_s, sample_a;
  logic [5:0] dac_m, dac_s, dac_a;
  logic [1:0] ch_m, ch_s, ch_a;
  logic       busy_m, busy_s, busy_a;
  logic [5:0] res_m, res_s, res_a;
  logic [1:0] rch_m, rch_s, rch_a;
  logic       valid_m, valid_s, valid_a;
  logic       eoc_m, eoc_s, eoc_a;

  int vin [4] = '{0, 0, 0, 0};
  int avg_seq [4] = '{10, 11, 11, 12};
  int trial [6] = '{32, 48, 40, 36, 38, 37};
  int avg_vin = 0;
  int avg_idx = 0;
  logic samp_a_q = 1'b0;

  logic [7:0] q_m[$], q_s[$], q_a[$];
  int n_checks = 0;
  int n_fail = 0;
  int eoc_cnt = 0;
  int eoc_base;

  // Comparator models: keep the trial bit while Vin >= Vdac
  assign cmp_m = (vin[ch_m] >= int'(dac_m));
  assign cmp_s = (vin[ch_s] >= int'(dac_s));
  assign cmp_a = (avg_vin >= int'(dac_a));

  always #5 clk = ~clk;

  fsm_sar_mc dut_m (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_m), .cont_i(cont), .abort_i(abort),
    .ch_mask_i(mask), .cmp_i(cmp_m), .sample_o(sample_m), .dac_o(dac_m), .ch_sel_o(ch_m),
    .busy_o(busy_m), .result_o(res_m), .result_ch_o(rch_m), .result_valid_o(valid_m),
    .result_ready_i(ready), .eoc_o(eoc_m));

  fsm_sar_mc #(.SettleCycles(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s), .cont_i(cont), .abort_i(abort),
    .ch_mask_i(mask), .cmp_i(cmp_s), .sample_o(sample_s), .dac_o(dac_s), .ch_sel_o(ch_s),
    .busy_o(busy_s), .result_o(res_s), .result_ch_o(rch_s), .result_valid_o(valid_s),
    .result_ready_i(ready), .eoc_o(eoc_s));

  fsm_sar_mc #(.AvgLog2(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .cont_i(cont), .abort_i(abort),
    .ch_mask_i(mask), .cmp_i(cmp_a), .sample_o(sample_a), .dac_o(dac_a), .ch_sel_o(ch_a),
    .busy_o(busy_a), .result_o(res_a), .result_ch_o(rch_a), .result_valid_o(valid_a),
    .result_ready_i(ready), .eoc_o(eoc_a));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_m();
    return int'({sample_m, dac_m, ch_m, busy_m, res_m, rch_m, valid_m, eoc_m});
  endfunction

  function automatic logic pending(input int which);
    case (which)
      0:       return busy_m || valid_m;
      1:       return busy_s || valid_s;
      default: return busy_a || valid_a;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int which);
    case (which)
      0:       start_m = 1'b1;
      1:       start_s = 1'b1;
      default: start_a = 1'b1;
    endcase
    tick(1);
    start_m = 1'b0;
    start_s = 1'b0;
    start_a = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget);
    int k;
    k = 0;
    while (pending(which) && k < budget) begin
      tick(1);
      k++;
    end
    check("idle_timeout", int'(pending(which)), 0);
  endtask

  // Scoreboard monitor and eoc counter
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_m && ready) begin
        if (q_m.size() == 0) check("unexpected_m", int'({rch_m, res_m}), -1);
        else check("result_m", int'({rch_m, res_m}), int'(q_m.pop_front()));
      end
      if (valid_s && ready) begin
        if (q_s.size() == 0) check("unexpected_s", int'({rch_s, res_s}), -1);
        else check("result_s", int'({rch_s, res_s}), int'(q_s.pop_front()));
      end
      if (valid_a && ready) begin
        if (q_a.size() == 0) check("unexpected_a", int'({rch_a, res_a}), -1);
        else check("result_a", int'({rch_a, res_a}), int'(q_a.pop_front()));
      end
      if (eoc_m) eoc_cnt++;
    end
  end

  // Per-conversion input sequence for the averaging instance
  always @(negedge clk) begin
    if (sample_a && !samp_a_q && avg_idx < 4) begin
      avg_vin = avg_seq[avg_idx];
      avg_idx++;
    end
    samp_a_q = sample_a;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extremes [2] = '{0, 63};
    tick(3);
    check("reset_outputs", outs_m(), 0);
    check("reset_busy_s", int'(busy_s), 0);
    rst_n = 1'b1;
    tick(1);

    // Single conversion, Vin = 37 on channel 0
    vin[0] = 37;
    mask = 4'b0001;
    q_m.push_back({2'd0, 6'd37});
    eoc_base = eoc_cnt;
    pulse_start(0);
    check("sample_e0", int'(sample_m), 1);
    check("busy_e0", int'(busy_m), 1);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k == 1) check("sample_e1", int'(sample_m), 1);
      if (k >= 2 && k <= 7) check("dac_seq", int'(dac_m), trial[k-2]);
      if (k == 8) check("valid_early", int'(valid_m), 0);
      if (k == 9) begin
        check("valid_cycle9", int'(valid_m), 1);
        check("eoc_cycle9", int'(eoc_m), 1);
      end
    end
    wait_idle(0, 50);
    check("eoc_single", eoc_cnt - eoc_base, 1);

    // Extremes
    for (int i = 0; i < 2; i++) begin
      vin[0] = extremes[i];
      q_m.push_back({2'd0, 6'(extremes[i])});
      pulse_start(0);
      wait_idle(0, 50);
    end

    // Scan of channels 1 and 3
    vin[1] = 5;
    vin[3] = 60;
    mask = 4'b1010;
    q_m.push_back({2'd1, 6'd5});
    q_m.push_back({2'd3, 6'd60});
    eoc_base = eoc_cnt;
    pulse_start(0);
    wait_idle(0, 100);
    check("eoc_scan", eoc_cnt - eoc_base, 1);

    // Empty mask ignores start
    mask = 4'b0000;
    pulse_start(0);
    tick(2);
    check("empty_mask_busy", int'(busy_m), 0);

    // Backpressure into HOLD
    vin[0] = 20;
    vin[1] = 45;
    mask = 4'b0011;
    cont = 1'b1;
    ready = 1'b0;
    q_m.push_back({2'd0, 6'd20});
    q_m.push_back({2'd1, 6'd45});
    eoc_base = eoc_cnt;
    pulse_start(0);
    tick(30);
    check("hold_busy", int'(busy_m), 1);
    check("hold_valid", int'(valid_m), 1);
    check("hold_sample", int'(sample_m), 0);
    check("hold_result", int'({rch_m, res_m}), int'({2'd0, 6'd20}));
    tick(5);
    check("hold_frozen", int'({rch_m, res_m}), int'({2'd0, 6'd20}));
    check("hold_dac", int'(dac_m), 45);
    cont = 1'b0;
    ready = 1'b1;
    wait_idle(0, 50);
    check("eoc_backpressure", eoc_cnt - eoc_base, 1);

    // Abort on the third bit
    vin[0] = 37;
    mask = 4'b0001;
    eoc_base = eoc_cnt;
    pulse_start(0);
    tick(4);
    check("abort_dac_bit3", int'(dac_m), 40);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", int'(busy_m), 0);
    check("abort_dac", int'(dac_m), 0);
    tick(12);
    check("abort_no_result", int'(valid_m), 0);
    check("abort_no_eoc", eoc_cnt - eoc_base, 0);

    // Asynchronous reset mid-conversion
    pulse_start(0);
    tick(3);
    check("pre_reset_busy", int'(busy_m), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_m(), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Settle time of three extra cycles
    vin[0] = 37;
    mask = 4'b0001;
    q_s.push_back({2'd0, 6'd37});
    pulse_start(1);
    for (int k = 1; k <= 27; k++) begin
      tick(1);
      if (k >= 2 && k <= 25) check("dac_settle", int'(dac_s), trial[(k-2)/4]);
      if (k == 26) check("valid_s_early", int'(valid_s), 0);
      if (k == 27) check("valid_s_cycle27", int'(valid_s), 1);
    end
    wait_idle(1, 50);

    // Average of four conversions: 10, 11, 11, 12
    q_a.push_back({2'd0, 6'd11});
    pulse_start(2);
    wait_idle(2, 200);
    check("avg_conversions", avg_idx, 4);

    tick(2);
    check("q_m_left", q_m.size(), 0);
    check("q_s_left", q_s.size(), 0);
    check("q_a_left", q_a.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
